mod_sub_stream: RTL and testbench

//   Streaming coefficient-wise modular subtractor: out = (a - b) mod KYBER_Q, one

---
 rtl/mod_sub_stream.sv | 121 ++++++++++++
 tb/tb_mod_sub_stream.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_stream.sv
// mod_sub_stream: streaming coefficient-wise modular subtractor.
// Computes out_o = (a_i - b_i) mod Q, one pair per cycle, through a two-stage
// valid/ready pipeline. A coefficient counter frames N-beat polynomials and
// raises out_last on the final beat of each one.
// Optional feature: define MOD_SUB_RANGE_CHECK_EN to build sticky range
// checking of the inputs on err_o. Without it err_o is tied low.
`timescale 1ns/1ps

`ifndef DWIDTH
`define DWIDTH 12
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

module mod_sub_stream #(
  parameter int DW = `DWIDTH,
  parameter int Q  = `KYBER_Q,
  parameter int N  = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_o,
  output logic          out_last,
  output logic          err_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  // Adding Q modulo 2^DW undoes the wrap caused by a borrow, so only the
  // low DW bits of the modulus are ever needed.
  localparam logic [DW-1:0] Q_LOW = DW'(Q);

  logic          s1_valid;
  logic [DW:0]   s1_diff;
  logic          s2_valid;
  logic [DW-1:0] out_q;
  logic [CW-1:0] cnt;
  logic          s1_load;
  logic          s2_load;
  logic [DW-1:0] corrected;

  // Stage advance: a stage loads when it is empty or its contents move on
  // this cycle, which lets data flow continuously with no bubbles.
  always_comb begin
    s2_load   = !s2_valid || out_ready;
    s1_load   = !s1_valid || s2_load;
    corrected = s1_diff[DW] ? (s1_diff[DW-1:0] + Q_LOW) : s1_diff[DW-1:0];
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign out_o     = out_q;
  assign out_last  = s2_valid && (cnt == LAST_CNT);

  // Stage 1 captures the raw difference with an extra MSB acting as borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff <= {1'b0, a_i} - {1'b0, b_i};
      end
    end
  end

  // Stage 2 folds a negative difference back into the canonical range.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_q <= corrected;
      end
    end
  end

  // Frame counter steps on every output handshake and wraps after N beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2_valid && out_ready) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MOD_SUB_RANGE_CHECK_EN
  localparam logic [DW:0] Q_EXT = (DW+1)'(Q);

  logic err_q;

  // Sticky flag for any accepted operand outside [0, Q-1]; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid && s1_load &&
                 (({1'b0, a_i} >= Q_EXT) || ({1'b0, b_i} >= Q_EXT))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub_stream.sv
// tb_mod_sub_stream: directed self-checking bench for mod_sub_stream.
// Each task drives one scenario and checks the DUT inline against values
// worked out by hand or by a simple modular-arithmetic model.
`timescale 1ns/1ps

module tb_mod_sub_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_i;
  logic [11:0] b_i;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_o;
  logic        out_last;
  logic        err_o;

  int compared;
  int mismatched;

  mod_sub_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_o     (out_o),
    .out_last  (out_last),
    .err_o     (err_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Holds reset for two edges and releases it 1 ns after an edge.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset values of every output.
  task automatic test_reset();
    do_reset();
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    compared++;
    if (out_o !== 12'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_o: got %0d want 0", out_o);
    end
    compared++;
    if (out_last !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_last: got %b want 0", out_last);
    end
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_err_o: got %b want 0", err_o);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Single pairs with hand-computed results, including borrow and boundaries.
  task automatic test_basic();
    int av[6] = '{5, 3, 0, 3328, 1700, 0};
    int bv[6] = '{3, 5, 3328, 0, 1700, 0};
    int ev[6] = '{2, 3327, 1, 3328, 0, 0};
    for (int i = 0; i < 6; i++) begin
      a_i       = 12'(av[i]);
      b_i       = 12'(bv[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_i      = '0;
      b_i      = '0;
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b1 || out_o !== 12'(ev[i])) begin
        mismatched++;
        $display("[TB] FAIL basic_result[%0d] %0d-%0d: got valid=%b out=%0d want valid=1 out=%0d",
                 i, av[i], bv[i], out_valid, out_o, ev[i]);
      end
      compared++;
      if (out_last !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL basic_last[%0d]: got %b want 0", i, out_last);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // 257 back-to-back pairs: one output per cycle, out_last only on beat 256.
  task automatic test_back_to_back();
    int   beat;
    int   ea;
    int   eb;
    int   e;
    logic exp_v;
    logic exp_l;
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 261; t++) begin
      if (t < 257) begin
        in_valid = 1'b1;
        a_i      = 12'((t * 13) % 3329);
        b_i      = 12'((t * 29 + 7) % 3329);
      end else begin
        in_valid = 1'b0;
        a_i      = '0;
        b_i      = '0;
      end
      #1;
      beat  = t - 2;
      exp_v = (t >= 2) && (t < 259);
      compared++;
      if (out_valid !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL b2b_valid[t=%0d]: got %b want %b", t, out_valid, exp_v);
      end
      if (exp_v) begin
        ea    = (beat * 13) % 3329;
        eb    = (beat * 29 + 7) % 3329;
        e     = (ea - eb + 3329) % 3329;
        exp_l = (beat == 255);
        compared++;
        if (out_o !== 12'(e)) begin
          mismatched++;
          $display("[TB] FAIL b2b_data[beat=%0d]: got %0d want %0d", beat, out_o, e);
        end
        compared++;
        if (out_last !== exp_l) begin
          mismatched++;
          $display("[TB] FAIL b2b_last[beat=%0d]: got %b want %b", beat, out_last, exp_l);
        end
      end
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_in_ready[t=%0d]: got %b want 1", t, in_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // 1024 pairs under random backpressure against a queue of expected results.
  task automatic test_backpressure();
    int          q[$];
    int          sent;
    int          recv;
    int          cyc;
    int          e;
    int          ea;
    int          eb;
    logic        prev_stall;
    logic [11:0] prev_o;
    logic        prev_last;
    logic        exp_ir;
    logic        exp_l;
    logic        in_hs;
    logic        out_hs;
    do_reset();
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_o     = '0;
    prev_last  = 1'b0;
    while (recv < 1024 && cyc < 20000) begin
      if (sent < 1024) begin
        in_valid = 1'b1;
        a_i      = 12'((sent * 1103 + 17) % 3329);
        b_i      = 12'((sent * 2311 + 5) % 3329);
      end else begin
        in_valid = 1'b0;
        a_i      = '0;
        b_i      = '0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        compared++;
        if (out_valid !== 1'b1 || out_o !== prev_o || out_last !== prev_last) begin
          mismatched++;
          $display("[TB] FAIL bp_stall_hold[cyc=%0d]: got v=%b o=%0d l=%b want v=1 o=%0d l=%b",
                   cyc, out_valid, out_o, out_last, prev_o, prev_last);
        end
      end
      exp_ir = !(q.size() == 2 && !out_ready);
      compared++;
      if (in_ready !== exp_ir) begin
        mismatched++;
        $display("[TB] FAIL bp_in_ready[cyc=%0d]: got %b want %b", cyc, in_ready, exp_ir);
      end
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL bp_spurious[cyc=%0d]: got out=%0d want no output", cyc, out_o);
        end else begin
          e     = q.pop_front();
          exp_l = ((recv % 256) == 255);
          compared++;
          if (out_o !== 12'(e)) begin
            mismatched++;
            $display("[TB] FAIL bp_data[beat=%0d]: got %0d want %0d", recv, out_o, e);
          end
          compared++;
          if (out_last !== exp_l) begin
            mismatched++;
            $display("[TB] FAIL bp_last[beat=%0d]: got %b want %b", recv, out_last, exp_l);
          end
        end
        recv++;
      end
      if (in_hs) begin
        ea = (sent * 1103 + 17) % 3329;
        eb = (sent * 2311 + 5) % 3329;
        q.push_back((ea - eb + 3329) % 3329);
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = out_o;
      prev_last  = out_last;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compared++;
    if (recv != 1024 || q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL bp_complete: got recv=%0d pending=%0d want recv=1024 pending=0",
               recv, q.size());
    end
  endtask

  // Reset with both stages full after 100 beats, then a clean new frame.
  task automatic test_reset_midstream();
    int   beat;
    int   ea;
    int   eb;
    int   e;
    logic exp_v;
    logic exp_l;
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 102; t++) begin
      in_valid = 1'b1;
      a_i      = 12'((t * 13) % 3329);
      b_i      = 12'((t * 29 + 7) % 3329);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b1;
    a_i       = 12'd102;
    b_i       = 12'd1;
    out_ready = 1'b0;
    #1;
    e = ((100 * 13) % 3329 - (100 * 29 + 7) % 3329 + 3329) % 3329;
    compared++;
    if (out_valid !== 1'b1 || out_o !== 12'(e)) begin
      mismatched++;
      $display("[TB] FAIL mid_full_out: got v=%b o=%0d want v=1 o=%0d", out_valid, out_o, e);
    end
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_full_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_o !== 12'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_after_rst: got v=%b l=%b o=%0d want v=0 l=0 o=0",
               out_valid, out_last, out_o);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_in_ready_release: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    for (int t = 0; t < 259; t++) begin
      if (t < 256) begin
        in_valid = 1'b1;
        a_i      = 12'((t * 7 + 100) % 3329);
        b_i      = 12'((t * 11) % 3329);
      end else begin
        in_valid = 1'b0;
        a_i      = '0;
        b_i      = '0;
      end
      #1;
      beat  = t - 2;
      exp_v = (t >= 2) && (t < 258);
      compared++;
      if (out_valid !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL mid_valid[t=%0d]: got %b want %b", t, out_valid, exp_v);
      end
      if (exp_v) begin
        ea    = (beat * 7 + 100) % 3329;
        eb    = (beat * 11) % 3329;
        e     = (ea - eb + 3329) % 3329;
        exp_l = (beat == 255);
        compared++;
        if (out_o !== 12'(e)) begin
          mismatched++;
          $display("[TB] FAIL mid_data[beat=%0d]: got %0d want %0d", beat, out_o, e);
        end
        compared++;
        if (out_last !== exp_l) begin
          mismatched++;
          $display("[TB] FAIL mid_last[beat=%0d]: got %b want %b", beat, out_last, exp_l);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Sticky range error with the checker built in; err_o stuck low otherwise.
  task automatic test_range_check();
    do_reset();
    out_ready = 1'b1;
`ifdef MOD_SUB_RANGE_CHECK_EN
    in_valid = 1'b1;
    a_i      = 12'd3328;
    b_i      = 12'd3328;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL range_edge_ok: got %b want 0", err_o);
    end
    in_valid = 1'b1;
    a_i      = 12'd3329;
    b_i      = 12'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i      = 12'd10;
    b_i      = 12'd4;
    compared++;
    if (err_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL range_set: got %b want 1", err_o);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (err_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL range_sticky: got %b want 1", err_o);
    end
    do_reset();
    #1;
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL range_clear: got %b want 0", err_o);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_i       = 12'd0;
    b_i       = 12'd3329;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compared++;
    if (err_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL range_set_b: got %b want 1", err_o);
    end
`else
    in_valid = 1'b1;
    a_i      = 12'd3329;
    b_i      = 12'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL range_disabled_now: got %b want 0", err_o);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL range_disabled_later: got %b want 0", err_o);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a_i        = '0;
    b_i        = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_range_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
